// File: rtl/trade_pkg.sv
// Shared types and constants for the trade order controller.
//   ctrl_state_t : FSM state encoding, exported on ctrl_state
//   SIDE_BUY/SIDE_SELL : order_side encoding
//   DROP_CNT_W   : width of the discarded-signal counter
package trade_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } ctrl_state_t;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/trade_cooldown_timer.sv
// Loadable down-counter that times the post-order cooldown.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value loaded on load
//   done     : count is zero
module trade_cooldown_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/trade_order_ctrl.sv
// Turns qualified buy/sell decisions from the SMA signal generator into a
// single rate-limited order stream with a net-position limit, a post-order
// cooldown and a valid/ready handshake. Discarded signals are counted.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable         : arms order generation in IDLE
//   data_valid_sma : buy_signal/sell_signal valid this cycle
//   buy_signal     : buy decision
//   sell_signal    : sell decision
//   order_ready    : downstream accepts the order this cycle
//   order_valid    : order present on order_side
//   order_side     : 1 = buy, 0 = sell
//   position       : signed net position (buys minus sells)
//   ctrl_state     : FSM state encoding
//   drop_cnt       : saturating count of discarded signals
module trade_order_ctrl
  import trade_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 16,
  parameter int POS_LIMIT       = 4,
  parameter int POS_W           = $clog2(POS_LIMIT + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    data_valid_sma,
  input  logic                    buy_signal,
  input  logic                    sell_signal,
  input  logic                    order_ready,
  output logic                    order_valid,
  output logic                    order_side,
  output logic signed [POS_W-1:0] position,
  output logic [1:0]              ctrl_state,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  // The timer holds COOLDOWN_CYCLES-1; keep it at least one bit wide so the
  // zero-cooldown build still elaborates (the timer is never loaded there).
  localparam int CNT_W      = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int LOAD_INT   = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_INT);

  localparam logic signed [POS_W-1:0] POS_MAX = POS_W'(POS_LIMIT);
  localparam logic signed [POS_W-1:0] POS_MIN = -POS_MAX;
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  ctrl_state_t                r_state;
  ctrl_state_t                w_state_nxt;
  logic                       r_order_valid;
  logic                       w_valid_nxt;
  logic                       r_order_side;
  logic                       w_side_nxt;
  logic signed [POS_W-1:0]    r_position;
  logic signed [POS_W-1:0]    w_pos_nxt;
  logic [DROP_CNT_W-1:0]      r_drop_cnt;
  logic                       w_drop;
  logic                       w_load;
  logic                       w_cd_done;
  logic                       w_event;
  logic                       w_handshake;

  assign w_event     = data_valid_sma && (buy_signal || sell_signal);
  assign w_handshake = r_order_valid && order_ready;

  trade_cooldown_timer #(
    .CNT_W (CNT_W)
  ) u_cooldown (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (LOAD_VAL),
    .done     (w_cd_done)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_order_valid;
    w_side_nxt  = r_order_side;
    w_pos_nxt   = r_position;
    w_drop      = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (enable && w_event) begin
          if (buy_signal && sell_signal) begin
            w_drop = 1'b1;
          end else if (buy_signal) begin
            if (r_position < POS_MAX) begin
              w_side_nxt  = SIDE_BUY;
              w_valid_nxt = 1'b1;
              w_state_nxt = ISSUE;
            end else begin
              w_drop = 1'b1;
            end
          end else begin
            if (r_position > POS_MIN) begin
              w_side_nxt  = SIDE_SELL;
              w_valid_nxt = 1'b1;
              w_state_nxt = ISSUE;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
      end

      ISSUE: begin
        // The FSM is busy, so any event here is discarded, even one arriving
        // together with the handshake.
        w_drop = w_event;
        if (w_handshake) begin
          w_valid_nxt = 1'b0;
          w_pos_nxt   = (r_order_side == SIDE_BUY) ? r_position + POS_ONE
                                                   : r_position - POS_ONE;
          if (COOLDOWN_CYCLES > 0) begin
            w_load      = 1'b1;
            w_state_nxt = COOLDOWN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      COOLDOWN: begin
        w_drop = w_event;
        if (w_cd_done) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        // Unused encoding: recover without emitting an order.
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_order_valid <= 1'b0;
      r_order_side  <= SIDE_SELL;
      r_position    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_order_valid <= w_valid_nxt;
      r_order_side  <= w_side_nxt;
      r_position    <= w_pos_nxt;
    end
  end

  // Saturating telemetry counter: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign order_valid = r_order_valid;
  assign order_side  = r_order_side;
  assign position    = r_position;
  assign ctrl_state  = r_state;
  assign drop_cnt    = r_drop_cnt;

endmodule
